// File: rtl/serial_sub_sequencer.sv
// serial_sub_sequencer: WIDTH-bit A - B computed one nibble per clock through
// an external 4-bit subtractor slice, LSB nibble first, with a start/busy/done
// handshake and accumulated N/Z/C/V flags.
// Optional feature: define SERIAL_SUB_CHAIN_EN to add the 'bin' borrow-in port
// (computes A - B - bin for chaining wider subtractions).
module serial_sub_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_CHAIN_EN
   input  logic             bin,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             n,
   output logic             z,
   output logic             c,
   output logic             v,
   output logic [3:0]       slice_a,
   output logic [3:0]       slice_b,
   output logic             slice_bin,
   input  logic [3:0]       slice_diff,
   input  logic             slice_bout
);

   localparam int unsigned NSLICE = WIDTH / 4;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_z_acc;
   logic             r_n;
   logic             r_z;
   logic             r_c;
   logic             r_v;
   logic             w_run;
   logic             w_accept;
   logic             w_last;
   logic             w_borrow_init;
   logic             w_diff_zero;
   logic [WIDTH-1:0] w_result_nxt;

`ifdef SERIAL_SUB_CHAIN_EN
   assign w_borrow_init = bin;
`else
   assign w_borrow_init = 1'b0;
`endif

   assign w_accept     = (r_state == S_IDLE) && start;
   assign w_last       = (r_state == S_RUN) && (r_cnt == CW'(NSLICE - 1));
   assign w_diff_zero  = (slice_diff == 4'd0);
   // New difference nibble enters at the top; after NSLICE shifts the word is aligned.
   assign w_result_nxt = (r_result >> 4) | (WIDTH'(slice_diff) << (WIDTH - 4));

   assign result = r_result;
   assign n      = r_n;
   assign z      = r_z;
   assign c      = r_c;
   assign v      = r_v;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and handshake / slice outputs
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      w_run       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy  = 1'b1;
            w_run = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      slice_a   = w_run ? r_a[3:0] : 4'd0;
      slice_b   = w_run ? r_b[3:0] : 4'd0;
      slice_bin = w_run ? r_borrow : 1'b0;
   end

   // Operand capture, nibble shifting, borrow chain and flag accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_z_acc  <= 1'b0;
         r_n      <= 1'b0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
      end else if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_borrow <= w_borrow_init;
         r_cnt    <= '0;
         r_a_msb  <= a[WIDTH-1];
         r_b_msb  <= b[WIDTH-1];
         r_z_acc  <= 1'b1;
      end else if (r_state == S_RUN) begin
         r_a      <= r_a >> 4;
         r_b      <= r_b >> 4;
         r_result <= w_result_nxt;
         r_borrow <= slice_bout;
         r_cnt    <= r_cnt + CW'(1);
         r_z_acc  <= r_z_acc & w_diff_zero;
         // Flags track the newest nibble; the values left after the last RUN edge are final.
         r_n      <= slice_diff[3];
         r_z      <= r_z_acc & w_diff_zero;
         r_c      <= slice_bout;
         r_v      <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ slice_diff[3]);
      end
   end

endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Self-checking bench for serial_sub_sequencer (WIDTH=16). The external 4-bit
// subtractor is modelled here; expected words come from a full-width model.
module tb_serial_sub_sequencer;

   localparam int NSL = 4;

   typedef struct packed {
      logic [15:0] r;
      logic        n;
      logic        z;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        n;
   logic        z;
   logic        c;
   logic        v;
   logic [3:0]  slice_a;
   logic [3:0]  slice_b;
   logic        slice_bin;
   logic [3:0]  slice_diff;
   logic        slice_bout;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   serial_sub_sequencer #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
`ifdef SERIAL_SUB_CHAIN_EN
      .bin        (bin),
`endif
      .busy       (busy),
      .done       (done),
      .result     (result),
      .n          (n),
      .z          (z),
      .c          (c),
      .v          (v),
      .slice_a    (slice_a),
      .slice_b    (slice_b),
      .slice_bin  (slice_bin),
      .slice_diff (slice_diff),
      .slice_bout (slice_bout)
   );

   always #5 clk = ~clk;

   // External 4-bit subtractor slice
   always_comb begin
      logic [4:0] t;
      t          = {1'b0, slice_a} - {1'b0, slice_b} - {4'd0, slice_bin};
      slice_diff = t[3:0];
      slice_bout = t[4];
   end

   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
      exp_t        m;
      logic [16:0] d;
      int          sd;
      d   = {1'b0, x} - {1'b0, y} - {16'd0, bi};
      sd  = int'($signed(x)) - int'($signed(y)) - int'(bi);
      m.r = d[15:0];
      m.n = d[15];
      m.z = (d[15:0] == 16'd0);
      m.c = d[16];
      m.v = (sd < -32768) || (sd > 32767);
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Drives one start cycle (caller guarantees IDLE) and records the expected outcome.
   task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic bi);
      a     = x;
      b     = y;
      bin   = bi;
      start = 1'b1;
      exp_q.push_back(model(x, y, bi));
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (3) step();
      total++;
      if ({busy, done, n, z, c, v, slice_bin, slice_a, slice_b, result} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b res=%h nzcv=%b%b%b%b sa=%h sb=%h sbin=%b, want all 0",
                  busy, done, result, n, z, c, v, slice_a, slice_b, slice_bin);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [15:0] xa;
      logic [15:0] xb;
      xa = 16'h1234;
      xb = 16'h0234;
      start_op(xa, xb, 1'b0);
      for (int i = 0; i < NSL; i++) begin
         total++;
         if (slice_a !== xa[i*4 +: 4] || slice_b !== xb[i*4 +: 4] || slice_bin !== 1'b0) begin
            bad++;
            $display("FAIL basic_slice[%0d]: got a=%h b=%h bin=%b, want a=%h b=%h bin=0",
                     i, slice_a, slice_b, slice_bin, xa[i*4 +: 4], xb[i*4 +: 4]);
         end
         total++;
         if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_run[%0d]: got busy=%b done=%b, want busy=1 done=0", i, busy, done);
         end
         step();
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b1 || {slice_a, slice_b, slice_bin} !== 9'd0) begin
         bad++;
         $display("FAIL basic_done: got done=%b busy=%b slices=%h/%h/%b, want done=1 busy=1 slices 0",
                  done, busy, slice_a, slice_b, slice_bin);
      end
      repeat (3) step();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h1000 || {n, z, c, v} !== 4'b0000) begin
         bad++;
         $display("FAIL basic_hold: got busy=%b done=%b res=%h nzcv=%b%b%b%b, want 0 0 1000 0000",
                  busy, done, result, n, z, c, v);
      end
   endtask

   task automatic test_borrow_ripple();
      logic [3:0] want_bin;
      want_bin = 4'b1110;
      start_op(16'h0000, 16'h0001, 1'b0);
      for (int i = 0; i < NSL; i++) begin
         total++;
         if (slice_bin !== want_bin[i]) begin
            bad++;
            $display("FAIL ripple_bin[%0d]: got %b, want %b", i, slice_bin, want_bin[i]);
         end
         step();
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL ripple_latency: done=%b, want 1", done);
      end
      step();
   endtask

   task automatic test_overflow_zero();
      logic [15:0] xs [2];
      logic [15:0] ys [2];
      xs[0] = 16'h8000; ys[0] = 16'h0001;
      xs[1] = 16'h5A5A; ys[1] = 16'h5A5A;
      for (int k = 0; k < 2; k++) begin
         start_op(xs[k], ys[k], 1'b0);
         repeat (NSL) step();
         total++;
         if (done !== 1'b1) begin
            bad++;
            $display("FAIL ovz_latency[%0d]: done=%b, want 1", k, done);
         end
         step();
      end
   endtask

   task automatic test_ignore_start();
      int dcount;
      dcount = 0;
      start_op(16'h1111, 16'h0001, 1'b0);
      step();
      a     = 16'hFFFF;
      b     = 16'h0000;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) dcount++;
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL ignore_busy[%0d]: busy=%b, want 1", i, busy);
         end
         step();
      end
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) dcount++;
         step();
      end
      total++;
      if (dcount != 1 || busy !== 1'b0 || result !== 16'h1110) begin
         bad++;
         $display("FAIL ignore_start: got pulses=%0d busy=%b res=%h, want 1 0 1110", dcount, busy, result);
      end
   endtask

   task automatic test_back_to_back();
      a     = 16'h0003;
      b     = 16'h0001;
      start = 1'b1;
      exp_q.push_back(model(16'h0003, 16'h0001, 1'b0));
      repeat (NSL + 1) step();
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first_done: done=%b, want 1", done);
      end
      step();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle_gap: busy=%b, want 0", busy);
      end
      a = 16'h0010;
      b = 16'h0001;
      exp_q.push_back(model(16'h0010, 16'h0001, 1'b0));
      step();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || slice_a !== 4'h0 || slice_b !== 4'h1) begin
         bad++;
         $display("FAIL b2b_second_accept: got busy=%b sa=%h sb=%h, want 1 0 1", busy, slice_a, slice_b);
      end
      repeat (NSL) step();
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL b2b_second_done: done=%b, want 1", done);
      end
      step();
   endtask

   task automatic test_reset_mid_run();
      int dcount;
      dcount = 0;
      start_op(16'h7777, 16'h1111, 1'b0);
      repeat (2) step();
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      total++;
      if ({busy, done, n, z, c, v, slice_bin, slice_a, slice_b, result} !== '0) begin
         bad++;
         $display("FAIL midrun_reset: got busy=%b done=%b res=%h nzcv=%b%b%b%b sa=%h, want all 0",
                  busy, done, result, n, z, c, v, slice_a);
      end
      for (int i = 0; i < 4; i++) begin
         if (done === 1'b1) dcount++;
         step();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) dcount++;
         step();
      end
      total++;
      if (dcount != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL midrun_no_done: got pulses=%0d busy=%b, want 0 0", dcount, busy);
      end
      start_op(16'h00FF, 16'h000F, 1'b0);
      repeat (NSL) step();
      total++;
      if (done !== 1'b1 || result !== 16'h00F0) begin
         bad++;
         $display("FAIL midrun_fresh: got done=%b res=%h, want 1 00F0", done, result);
      end
      step();
   endtask

`ifdef SERIAL_SUB_CHAIN_EN
   task automatic test_chain();
      start_op(16'h0010, 16'h0000, 1'b1);
      total++;
      if (slice_bin !== 1'b1) begin
         bad++;
         $display("FAIL chain_bin_init: slice_bin=%b, want 1", slice_bin);
      end
      repeat (NSL) step();
      step();
      start_op(16'h0000, 16'h0000, 1'b1);
      repeat (NSL) step();
      total++;
      if (done !== 1'b1 || result !== 16'hFFFF || c !== 1'b1) begin
         bad++;
         $display("FAIL chain_all_borrow: got done=%b res=%h c=%b, want 1 FFFF 1", done, result, c);
      end
      step();
      bin = 1'b0;
   endtask
`endif

   initial begin
      exp_t e;
      fork
         // Scoreboard consumer: every done pulse retires the oldest expected result.
         forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_unexpected_done: got done=1 res=%h, want no done", result);
               end else begin
                  e = exp_q.pop_front();
                  total++;
                  if (result !== e.r) begin
                     bad++;
                     $display("FAIL sb_result: got %h, want %h", result, e.r);
                  end
                  total++;
                  if ({n, z, c, v} !== {e.n, e.z, e.c, e.v}) begin
                     bad++;
                     $display("FAIL sb_flags(res=%h): got nzcv=%b%b%b%b, want %b%b%b%b",
                              e.r, n, z, c, v, e.n, e.z, e.c, e.v);
                  end
               end
            end
         end
         begin
            #200000;
            $display("FAIL watchdog: simulation time limit reached, want completion");
            $fatal(1, "watchdog");
         end
      join_none

      test_reset();
      test_basic();
      test_borrow_ripple();
      test_overflow_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
`ifdef SERIAL_SUB_CHAIN_EN
      test_chain();
`endif
      repeat (2) step();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: got %0d pending results, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_sub_sequencer.md
Name: serial_sub_sequencer

Overview:
Multi-cycle controller that performs a WIDTH-bit two's-complement subtraction A - B by time-multiplexing one external 4-bit subtractor slice. It processes one nibble per clock, least significant nibble first. The borrow is carried between cycles in a register. The block accumulates the N/Z/C/V flags over the full word and reports completion with a start/busy/done handshake. It sits between the lab's operand/control logic and the shared 4-bit subtractor datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4
NSLICE, WIDTH/4, derived slice count; not overridden by users

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result and flags valid
result  output  WIDTH  A - B, modulo 2^WIDTH
n  output  1  result[WIDTH-1]
z  output  1  result == 0
c  output  1  final borrow-out; 1 when A < B unsigned
v  output  1  signed overflow
slice_a  output  4  nibble to subtractor A
slice_b  output  4  nibble to subtractor B
slice_bin  output  1  borrow-in to subtractor
slice_diff  input  4  subtractor difference (combinational return)
slice_bout  input  1  subtractor borrow-out

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, result, n, z, c, v, slice_* all 0; internal shift registers, borrow and count all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads a and b into shift registers, clears the borrow register (see optional feature), sets count=0, latches a[WIDTH-1] and b[WIDTH-1], sets the z accumulator to 1, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - slice_a and slice_b are the low nibbles of the shift registers; slice_bin is the borrow register.
  - At the clock edge: slice_diff shifts into result from the top (result >> 4, diff in bits [WIDTH-1:WIDTH-4]); operand registers shift right by 4; borrow <= slice_bout; z_acc &= (slice_diff == 0); count++.
  - When count == NSLICE-1 at the edge, move to DONE.
- DONE (exactly 1 cycle):
  - done=1; n, z, c, v are valid and registered from the final values.
  - v = (a_msb ^ b_msb) & (a_msb ^ result[WIDTH-1]).
  - Next state is IDLE.
- Latency: start accepted at edge k; done high in the cycle after edge k+NSLICE (for WIDTH=16, done is high 5 cycles after start is sampled).
- Outside RUN, slice_a, slice_b and slice_bin are driven 0.
- result and flags hold their values after DONE until the next accepted start.
- result and flags are not cleared on start; they update during RUN.
- Consumers use them only when done=1 or while busy=0 after done.
- start while busy=1 is ignored; there is no queueing.
- start held high continuously: a new operation is accepted in the IDLE cycle following DONE.
- WIDTH=4: one RUN cycle, then DONE.
- rst_n low mid-RUN or in DONE: immediate return to IDLE with all outputs 0; the partial result is discarded and no done pulse is produced.

Optional Feature:
Macro SERIAL_SUB_CHAIN_EN.
- Defined: adds input port bin (1 bit). On an accepted start, the borrow register loads bin, so the block computes A - B - bin. This allows chaining wider subtractions, with c feeding the next word's bin.
- Undefined: there is no bin port and the initial borrow is always 0.
- Flag definitions are unchanged in both cases.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, start 1 cycle -> done 5 cycles later, result=0x1000, n=0 z=0 c=0 v=0; slice_a sequence 4,3,2,1.
- a=0x0000, b=0x0001 -> result=0xFFFF, n=1 z=0 c=1 v=0; borrow ripples through all 4 RUN cycles.
- a=0x8000, b=0x0001 -> result=0x7FFF, n=0 z=0 c=0 v=1; then a=0x5A5A, b=0x5A5A -> result=0x0000, z=1, c=0.
- start pulsed again during RUN and DONE with a different a/b -> ignored; first result intact; busy stays high through DONE and done pulses once.
- rst_n asserted 2 cycles into RUN -> outputs 0 in the same cycle; after release, a fresh start with a=0x00FF, b=0x000F gives 0x00F0.
- SERIAL_SUB_CHAIN_EN defined, bin=1, a=0x0010, b=0x0000 -> result=0x000F, c=0; bin=1, a=0, b=0 -> result=0xFFFF, c=1.
